// File: rtl/ni_pkg.sv
// ni_pkg: flit format constants, type codes and receive FSM states shared by the NI blocks.
package ni_pkg;
   localparam int FLIT_W  = 48;
   localparam int DATA_W  = 16;
   localparam int NODE_AW = 8;
   localparam int LEN_W   = 8;
   localparam int PW_W    = 9;
   localparam int TYPE_LO = 46;
   localparam int SRC_LO  = 38;
   localparam int DEST_LO = 30;
   localparam int LEN_LO  = 22;
   localparam int W0_LO   = 16;
   localparam int W1_LO   = 0;
   typedef enum logic [1:0] {FT_INV = 2'b00, FT_HF = 2'b01, FT_BF = 2'b10, FT_TF = 2'b11} flit_type_e;
   typedef enum logic [2:0] {S_IDLE, S_BODY, S_WR_LO, S_TAIL, S_DROP} rx_state_e;
   function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] f);
      return flit_type_e'(f[TYPE_LO+1:TYPE_LO]);
   endfunction
endpackage

// File: rtl/ni_rx_csum.sv
// ni_rx_csum: 16-bit XOR accumulator folding in two payload words per accumulate.
module ni_rx_csum
   import ni_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              acc_i,
   input  logic [DATA_W-1:0] w0_i,
   input  logic [DATA_W-1:0] w1_i,
   output logic [DATA_W-1:0] csum_o
);
   logic [DATA_W-1:0] csum_q, csum_d;
   always_comb csum_d = clr_i ? '0 : acc_i ? csum_q ^ w0_i ^ w1_i : csum_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) csum_q <= '0;
      else        csum_q <= csum_d;
   assign csum_o = csum_q;
endmodule

// File: rtl/ni_rx_sram_writer.sv
// ni_rx_sram_writer: NI receive path; filters packets by destination, unpacks body flits
// into pairs of SRAM writes and checks the tail checksum.
module ni_rx_sram_writer
   import ni_pkg::*;
#(
   parameter int SRAM_AW = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NODE_AW-1:0] local_addr_i,
   input  logic [FLIT_W-1:0]  flit_i,
   input  logic               flit_valid_i,
   output logic               flit_ready_o,
   output logic               sram_we_o,
   output logic [SRAM_AW-1:0] sram_addr_o,
   output logic [DATA_W-1:0]  sram_wdata_o,
   output logic [NODE_AW-1:0] pkt_src_o,
   output logic [PW_W-1:0]    pkt_words_o,
   output logic               pkt_done_o,
   output logic               pkt_err_o
);
   rx_state_e          state_q, state_d;
   logic [SRAM_AW-1:0] wr_ptr_q, wr_ptr_d, addr_q, addr_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [NODE_AW-1:0] src_q, src_d;
   logic [PW_W-1:0]    words_q, words_d;
   logic [2*DATA_W-1:0] bf_q, bf_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d, csum;
   logic               we_q, we_d, done_q, done_d, err_q, err_d, csum_clr, csum_acc, xfer;
   flit_type_e         ft;

   ni_rx_csum u_csum (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (csum_clr),
      .acc_i  (csum_acc),
      .w0_i   (bf_q[W0_LO +: DATA_W]),
      .w1_i   (bf_q[W1_LO +: DATA_W]),
      .csum_o (csum)
   );

   assign ft           = flit_type(flit_i);
   assign flit_ready_o = state_q != S_WR_LO;
   assign xfer         = flit_valid_i & flit_ready_o;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rem_d    = rem_q;
      src_d    = src_q;
      words_d  = words_q;
      bf_d     = bf_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      csum_clr = 1'b0;
      csum_acc = 1'b0;
      case (state_q)
         S_IDLE:
            if (xfer) begin
               if (ft != FT_HF) err_d = 1'b1;
               else if (flit_i[DEST_LO +: NODE_AW] != local_addr_i) state_d = S_DROP;
               else begin
                  src_d    = flit_i[SRC_LO +: NODE_AW];
                  rem_d    = flit_i[LEN_LO +: LEN_W];
                  words_d  = '0;
                  csum_clr = 1'b1;
                  state_d  = rem_d == '0 ? S_TAIL : S_BODY;
               end
            end
         S_BODY:
            if (xfer) begin
               if (ft == FT_BF) begin
                  we_d    = 1'b1;
                  addr_d  = wr_ptr_q;
                  wdata_d = flit_i[W0_LO +: DATA_W];
                  bf_d    = flit_i[2*DATA_W-1:0];
                  state_d = S_WR_LO;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         S_WR_LO: begin
            we_d     = 1'b1;
            addr_d   = wr_ptr_q + SRAM_AW'(1);
            wdata_d  = bf_q[W1_LO +: DATA_W];
            wr_ptr_d = wr_ptr_q + SRAM_AW'(2);
            words_d  = words_q >= PW_W'(509) ? '1 : words_q + PW_W'(2);
            rem_d    = rem_q - LEN_W'(1);
            csum_acc = 1'b1;
            state_d  = rem_d == '0 ? S_TAIL : S_BODY;
         end
         S_TAIL:
            if (xfer) begin
               done_d  = ft == FT_TF && flit_i[DATA_W-1:0] == csum;
               err_d   = !done_d;
               state_d = S_IDLE;
            end
         S_DROP: state_d = xfer && ft == FT_TF ? S_IDLE : S_DROP;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rem_q    <= '0;
         src_q    <= '0;
         words_q  <= '0;
         bf_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rem_q    <= rem_d;
         src_q    <= src_d;
         words_q  <= words_d;
         bf_q     <= bf_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end

   assign sram_we_o    = we_q;
   assign sram_addr_o  = addr_q;
   assign sram_wdata_o = wdata_q;
   assign pkt_src_o    = src_q;
   assign pkt_words_o  = words_q;
   assign pkt_done_o   = done_q;
   assign pkt_err_o    = err_q;
endmodule

// File: tb/tb_ni_rx_sram_writer.sv
// tb_ni_rx_sram_writer: directed vector table for ni_rx_sram_writer plus reset-in-flight sequence.
module tb_ni_rx_sram_writer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  local_addr = 8'h05;
   logic [47:0] flit = '0;
   logic        valid = 1'b0;
   logic        ready, we, done, err;
   logic [9:0]  addr;
   logic [15:0] wdata;
   logic [7:0]  src;
   logic [8:0]  words;
   int          total = 0, bad = 0, step = 0;

   typedef struct {
      logic [47:0] flit;
      logic        valid;
      logic        rdy;
      logic        we;
      logic [9:0]  addr;
      logic [15:0] data;
      logic        done;
      logic        err;
      logic [8:0]  words;
      logic [7:0]  src;
   } vec_t;
   vec_t tbl[$];

   ni_rx_sram_writer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .local_addr_i (local_addr),
      .flit_i       (flit),
      .flit_valid_i (valid),
      .flit_ready_o (ready),
      .sram_we_o    (we),
      .sram_addr_o  (addr),
      .sram_wdata_o (wdata),
      .pkt_src_o    (src),
      .pkt_words_o  (words),
      .pkt_done_o   (done),
      .pkt_err_o    (err)
   );

   always #5 clk = ~clk;

   function automatic logic [47:0] hf(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
      return {2'b01, s, d, l, 22'h0};
   endfunction
   function automatic logic [47:0] bf(input logic [15:0] w0, input logic [15:0] w1);
      return {2'b10, 14'h0, w0, w1};
   endfunction
   function automatic logic [47:0] tf(input logic [15:0] c);
      return {2'b11, 30'h0, c};
   endfunction

   function automatic vec_t mk(input logic [47:0] f, input logic v, input logic r, input logic w,
                               input logic [9:0] a, input logic [15:0] d, input logic dn,
                               input logic e, input logic [8:0] wc, input logic [7:0] s);
      vec_t x;
      x.flit = f; x.valid = v; x.rdy = r; x.we = w; x.addr = a; x.data = d;
      x.done = dn; x.err = e; x.words = wc; x.src = s;
      return x;
   endfunction

   function automatic void add(input logic [47:0] f, input logic v, input logic r, input logic w,
                               input logic [9:0] a, input logic [15:0] d, input logic dn,
                               input logic e, input logic [8:0] wc, input logic [7:0] s);
      tbl.push_back(mk(f, v, r, w, a, d, dn, e, wc, s));
   endfunction

   // Packet of len BFs carrying (k,k) so the checksum is 0; writes start at base.
   function automatic void add_fill(input logic [9:0] base, input int len);
      add(hf(8'h02, 8'h05, 8'(len)), 1, 1, 0, 0, 0, 0, 0, 0, 8'h02);
      for (int k = 0; k < len; k++) begin
         add(bf(16'(k), 16'(k)), 1, 1, 1, base + 10'(2*k), 16'(k), 0, 0, 9'(2*k), 8'h02);
         add(48'h0, 0, 0, 1, base + 10'(2*k+1), 16'(k), 0, 0, 9'(2*k+2), 8'h02);
      end
      add(tf(16'h0000), 1, 1, 0, 0, 0, 1, 0, 9'(2*len), 8'h02);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %0h want %0h", name, step, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      flit = v.flit;
      valid = v.valid;
      #1 chk("ready", 32'(ready), 32'(v.rdy));
      @(posedge clk);
      #1;
      chk("we", 32'(we), 32'(v.we));
      if (v.we) begin
         chk("addr", 32'(addr), 32'(v.addr));
         chk("wdata", 32'(wdata), 32'(v.data));
      end
      chk("done", 32'(done), 32'(v.done));
      chk("err", 32'(err), 32'(v.err));
      chk("words", 32'(words), 32'(v.words));
      chk("src", 32'(src), 32'(v.src));
      step++;
   endtask

   initial begin
      // good packet: csum 1111^2222^3333^4444 = 4444
      add(hf(8'h03, 8'h05, 8'd2), 1, 1, 0, 0, 0, 0, 0, 0, 8'h03);
      add(bf(16'h1111, 16'h2222), 1, 1, 1, 10'h000, 16'h1111, 0, 0, 0, 8'h03);
      add(48'h0, 0, 0, 1, 10'h001, 16'h2222, 0, 0, 2, 8'h03);
      add(bf(16'h3333, 16'h4444), 1, 1, 1, 10'h002, 16'h3333, 0, 0, 2, 8'h03);
      add(48'h0, 0, 0, 1, 10'h003, 16'h4444, 0, 0, 4, 8'h03);
      add(tf(16'h4444), 1, 1, 0, 0, 0, 1, 0, 4, 8'h03);
      add(48'h0, 0, 1, 0, 0, 0, 0, 0, 4, 8'h03);
      // same payload, wrong checksum
      add(hf(8'h03, 8'h05, 8'd2), 1, 1, 0, 0, 0, 0, 0, 0, 8'h03);
      add(bf(16'h1111, 16'h2222), 1, 1, 1, 10'h004, 16'h1111, 0, 0, 0, 8'h03);
      add(48'h0, 0, 0, 1, 10'h005, 16'h2222, 0, 0, 2, 8'h03);
      add(bf(16'h3333, 16'h4444), 1, 1, 1, 10'h006, 16'h3333, 0, 0, 2, 8'h03);
      add(48'h0, 0, 0, 1, 10'h007, 16'h4444, 0, 0, 4, 8'h03);
      add(tf(16'h0001), 1, 1, 0, 0, 0, 0, 1, 4, 8'h03);
      add(48'h0, 0, 1, 0, 0, 0, 0, 0, 4, 8'h03);
      // foreign packet dropped, including an HF inside it
      add(hf(8'h09, 8'h07, 8'd1), 1, 1, 0, 0, 0, 0, 0, 4, 8'h03);
      add(bf(16'hdead, 16'hbeef), 1, 1, 0, 0, 0, 0, 0, 4, 8'h03);
      add(hf(8'h01, 8'h05, 8'd3), 1, 1, 0, 0, 0, 0, 0, 4, 8'h03);
      add(tf(16'h0000), 1, 1, 0, 0, 0, 0, 0, 4, 8'h03);
      // zero-length packet straight to tail
      add(hf(8'h04, 8'h05, 8'd0), 1, 1, 0, 0, 0, 0, 0, 0, 8'h04);
      add(tf(16'h0000), 1, 1, 0, 0, 0, 1, 0, 0, 8'h04);
      // BF in IDLE
      add(bf(16'h1, 16'h2), 1, 1, 0, 0, 0, 0, 1, 0, 8'h04);
      add(48'h0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h04);
      // BF held valid through WR_LO, then TF in BODY
      add(hf(8'h06, 8'h05, 8'd2), 1, 1, 0, 0, 0, 0, 0, 0, 8'h06);
      add(bf(16'haaaa, 16'h5555), 1, 1, 1, 10'h008, 16'haaaa, 0, 0, 0, 8'h06);
      add(bf(16'haaaa, 16'h5555), 1, 0, 1, 10'h009, 16'h5555, 0, 0, 2, 8'h06);
      add(tf(16'h0000), 1, 1, 0, 0, 0, 0, 1, 2, 8'h06);
      add(48'h0, 0, 1, 0, 0, 0, 0, 0, 2, 8'h06);
      add(bf(16'h1, 16'h2), 1, 1, 0, 0, 0, 0, 1, 2, 8'h06);
      // non-TF in TAIL
      add(hf(8'h07, 8'h05, 8'd0), 1, 1, 0, 0, 0, 0, 0, 0, 8'h07);
      add(bf(16'h1, 16'h2), 1, 1, 0, 0, 0, 0, 1, 0, 8'h07);
      add(48'h0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h07);
      // advance wr_ptr 0x00A -> 0x3FE, then wrap
      add_fill(10'd10, 253);
      add_fill(10'd516, 253);
      add(hf(8'h02, 8'h05, 8'd1), 1, 1, 0, 0, 0, 0, 0, 0, 8'h02);
      add(bf(16'haaaa, 16'hbbbb), 1, 1, 1, 10'h3fe, 16'haaaa, 0, 0, 0, 8'h02);
      add(48'h0, 0, 0, 1, 10'h3ff, 16'hbbbb, 0, 0, 2, 8'h02);
      add(tf(16'h1111), 1, 1, 0, 0, 0, 1, 0, 2, 8'h02);
      add(hf(8'h02, 8'h05, 8'd1), 1, 1, 0, 0, 0, 0, 0, 0, 8'h02);
      add(bf(16'h1234, 16'h5678), 1, 1, 1, 10'h000, 16'h1234, 0, 0, 0, 8'h02);
      add(48'h0, 0, 0, 1, 10'h001, 16'h5678, 0, 0, 2, 8'h02);
      add(tf(16'h444c), 1, 1, 0, 0, 0, 1, 0, 2, 8'h02);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_we", 32'(we), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_words", 32'(words), 0);
      chk("rst_src", 32'(src), 0);
      chk("rst_ready", 32'(ready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) apply(tbl[i]);

      // reset asserted while in WR_LO
      apply(mk(hf(8'h03, 8'h05, 8'd1), 1, 1, 0, 0, 0, 0, 0, 0, 8'h03));
      apply(mk(bf(16'hcafe, 16'hf00d), 1, 1, 1, 10'h002, 16'hcafe, 0, 0, 0, 8'h03));
      valid = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("mid_rst_we", 32'(we), 0);
      chk("mid_rst_words", 32'(words), 0);
      chk("mid_rst_src", 32'(src), 0);
      chk("mid_rst_addr", 32'(addr), 0);
      chk("mid_rst_ready", 32'(ready), 1);
      chk("mid_rst_pulses", 32'({done, err}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk(hf(8'h03, 8'h05, 8'd1), 1, 1, 0, 0, 0, 0, 0, 0, 8'h03));
      apply(mk(bf(16'h0001, 16'h0002), 1, 1, 1, 10'h000, 16'h0001, 0, 0, 0, 8'h03));
      apply(mk(48'h0, 0, 0, 1, 10'h001, 16'h0002, 0, 0, 2, 8'h03));
      apply(mk(tf(16'h0003), 1, 1, 0, 0, 0, 1, 0, 2, 8'h03));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
